// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises data and fetch requests onto a single variable-latency RAM port,
// data first, with a sticky watchdog that traps a RAM that never signals completion.
`default_nettype none

module memory_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] imemload,
  output logic [DATA_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   store_q, store_d;
  logic                wen_q,   wen_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                in_dacc, in_iacc;

  assign cnt_inc = cnt_q + 1'b1;
  assign in_dacc = (state_q == DACC);
  assign in_iacc = (state_q == IACC);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wen_d   = wen_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dmemWEN || dmemREN) begin
          state_d = DACC;
          addr_d  = dmemaddr;
          store_d = dmemstore;
          wen_d   = dmemWEN;
          cnt_d   = '0;
        end else if (imemREN) begin
          state_d = IACC;
          addr_d  = imemaddr;
          store_d = '0;
          wen_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      DACC, IACC: begin
        // Completion on the final allowed cycle beats the watchdog.
        if (ramready) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            state_d = ERR;
          end
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign ramREN   = in_iacc || (in_dacc && !wen_q);
  assign ramWEN   = in_dacc && wen_q;
  assign ramaddr  = (in_dacc || in_iacc) ? addr_q : '0;
  assign ramstore = (in_dacc && wen_q) ? store_q : '0;

  // A hit needs the requester still asking for the same operation it was granted.
  assign dhit     = in_dacc && ramready && (wen_q ? dmemWEN : dmemREN);
  assign ihit     = in_iacc && ramready && imemREN;
  assign dmemload = dhit ? ramload : '0;
  assign imemload = ihit ? ramload : '0;

  assign err = (state_q == ERR);

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table vectors, hand sequences and randomized transactions checked
// against a transaction-level model of the arbiter.
`default_nettype none

module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN, dmemREN, dmemWEN;
  logic [31:0] imemaddr, dmemaddr, dmemstore;
  logic        ihit, dhit;
  logic [31:0] imemload, dmemload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        err;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .imemaddr(imemaddr), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // kind: 0 fetch, 1 data read, 2 data write, 3 read+write together
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] rdata;
    int          lat;
    bit          drop;
    bit          e_ren;
    bit          e_wen;
    logic [31:0] e_store;
    bit          e_hit;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_req();
    imemREN  = 1'b0;
    dmemREN  = 1'b0;
    dmemWEN  = 1'b0;
    ramready = 1'b0;
  endtask

  // Called at posedge+1 with the arbiter in IDLE; returns at posedge+1 back in IDLE.
  task automatic do_access(input vec_t v);
    imemREN   = (v.kind == 0);
    dmemREN   = (v.kind == 1) || (v.kind == 3);
    dmemWEN   = (v.kind >= 2);
    if (v.kind == 0) imemaddr = v.addr;
    else             dmemaddr = v.addr;
    dmemstore = v.store;
    ramready  = 1'b0;
    #1;
    chk("idle_ren", ramREN, 0);
    chk("idle_wen", ramWEN, 0);
    tick();
    for (int k = 1; k <= v.lat; k++) begin
      if (k == 1 && v.drop) begin
        imemREN = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
      end
      imemaddr  = $urandom;
      dmemaddr  = $urandom;
      dmemstore = $urandom;
      ramready  = (k == v.lat);
      ramload   = (k == v.lat) ? v.rdata : $urandom;
      #1;
      chk("acc_ren", ramREN, v.e_ren);
      chk("acc_wen", ramWEN, v.e_wen);
      chk("acc_addr", ramaddr, v.addr);
      chk("acc_store", ramstore, v.e_store);
      chk("acc_err", err, 0);
      if (k == v.lat) begin
        if (v.kind == 0) begin
          chk("ihit", ihit, v.e_hit);
          chk("dhit_other", dhit, 0);
          chk("imemload", imemload, v.e_hit ? v.rdata : 32'h0);
          chk("dmemload_other", dmemload, 0);
        end else begin
          chk("dhit", dhit, v.e_hit);
          chk("ihit_other", ihit, 0);
          chk("dmemload", dmemload, v.e_hit ? v.rdata : 32'h0);
          chk("imemload_other", imemload, 0);
        end
      end else begin
        chk("early_ihit", ihit, 0);
        chk("early_dhit", dhit, 0);
      end
      tick();
    end
    clear_req();
  endtask

  // Reference model: what any transaction of this kind must show on the RAM side.
  function automatic vec_t model(input int kind, input logic [31:0] addr, input logic [31:0] store,
                                 input logic [31:0] rdata, input int lat, input bit drop);
    vec_t v;
    v.kind    = kind;
    v.addr    = addr;
    v.store   = store;
    v.rdata   = rdata;
    v.lat     = lat;
    v.drop    = drop;
    v.e_wen   = (kind >= 2);
    v.e_ren   = !v.e_wen;
    v.e_store = v.e_wen ? store : 32'h0;
    v.e_hit   = !drop;
    return v;
  endfunction

  initial begin
    vecs[0] = '{0, 32'h40,  32'h0,        32'h8C010004, 3, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
    vecs[1] = '{1, 32'h200, 32'h1111,     32'hCAFEF00D, 1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
    vecs[2] = '{2, 32'h100, 32'hDEADBEEF, 32'h0,        2, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{3, 32'h104, 32'h12345678, 32'h5A5A5A5A, 4, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1};
    vecs[4] = '{1, 32'h300, 32'h0,        32'h77777777, 3, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[5] = '{0, 32'h48,  32'h0,        32'h13579BDF, 1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[6] = '{2, 32'h108, 32'hA5A5A5A5, 32'h0,        2, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0};

    nRST      = 1'b0;
    imemaddr  = '0;
    dmemaddr  = '0;
    dmemstore = '0;
    ramload   = '0;
    clear_req();
    tick();
    tick();
    chk("rst_ren", ramREN, 0);
    chk("rst_wen", ramWEN, 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_store", ramstore, 0);
    chk("rst_err", err, 0);
    chk("rst_hits", {ihit, dhit}, 0);
    nRST = 1'b1;

    foreach (vecs[i]) do_access(vecs[i]);

    // Simultaneous write and fetch: write first, fetch after one IDLE cycle.
    dmemWEN = 1'b1; dmemaddr = 32'h100; dmemstore = 32'hDEADBEEF;
    imemREN = 1'b1; imemaddr = 32'h44;
    tick();
    #1;
    chk("sim_wen", ramWEN, 1);
    chk("sim_ren", ramREN, 0);
    chk("sim_addr", ramaddr, 32'h100);
    tick();
    dmemstore = 32'h0BADC0DE; dmemaddr = 32'h999;
    ramready = 1'b1; ramload = 32'h0;
    #1;
    chk("sim_store_hold", ramstore, 32'hDEADBEEF);
    chk("sim_addr_hold", ramaddr, 32'h100);
    chk("sim_dhit", dhit, 1);
    chk("sim_ihit_low", ihit, 0);
    tick();
    dmemWEN = 1'b0; ramready = 1'b0;
    #1;
    chk("sim_idle_ren", ramREN, 0);
    chk("sim_idle_wen", ramWEN, 0);
    tick();
    ramready = 1'b1; ramload = 32'h24420001;
    #1;
    chk("sim_fetch_ren", ramREN, 1);
    chk("sim_fetch_addr", ramaddr, 32'h44);
    chk("sim_ihit", ihit, 1);
    chk("sim_imemload", imemload, 32'h24420001);
    tick();
    clear_req();

    for (int n = 0; n < 60; n++) begin
      do_access(model($urandom_range(0, 3), $urandom, $urandom, $urandom,
                      $urandom_range(1, 4), ($urandom_range(0, 3) == 0)));
    end

    // Asynchronous reset during a fetch.
    imemREN = 1'b1; imemaddr = 32'h60;
    tick();
    #1;
    chk("arst_pre_ren", ramREN, 1);
    #1;
    nRST = 1'b0; ramready = 1'b1; ramload = 32'hFFFF0000;
    #1;
    chk("arst_ren", ramREN, 0);
    chk("arst_addr", ramaddr, 0);
    chk("arst_ihit", ihit, 0);
    #1;
    nRST = 1'b1;
    clear_req();
    tick();
    #1;
    chk("arst_idle_ren", ramREN, 0);

    // Watchdog: RAM never completes.
    imemREN = 1'b1; imemaddr = 32'h80;
    tick();
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("wd_ren", ramREN, 1);
      chk("wd_err_low", err, 0);
      tick();
    end
    #1;
    chk("wd_err", err, 1);
    chk("wd_ren_off", ramREN, 0);
    chk("wd_addr_off", ramaddr, 0);
    imemREN = 1'b0; dmemWEN = 1'b1; dmemaddr = 32'h500; ramready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("wd_ignore_wen", ramWEN, 0);
      chk("wd_ignore_hit", {ihit, dhit}, 0);
      chk("wd_sticky", err, 1);
    end
    #1;
    nRST = 1'b0;
    #1;
    chk("wd_rst_clear", err, 0);
    #1;
    nRST = 1'b1;
    clear_req();
    tick();
    do_access(model(0, 32'h84, 32'h0, 32'h11223344, 2, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
